// File: rtl/ram_pkg.sv
// Shared types and constants for the four-bank interleaved RAM read path.
package ram_pkg;
    localparam int NUM_BANKS  = 4;
    localparam int BANK_SEL_W = 2;
    localparam int DATA_W     = 18;

    typedef logic [BANK_SEL_W-1:0] bank_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input bank_sel_t b);
        logic [NUM_BANKS-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/rd_lat_pipe.sv
// RD_LAT-deep {valid, bank} shift register that lines the mux select up with returning RAM data.
module rd_lat_pipe
    import ram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic      clk,
    input  logic      i_clr,
    input  logic      i_vld,
    input  bank_sel_t i_sel,
    output logic      o_vld,
    output bank_sel_t o_sel,
    output logic      o_pend
);
    localparam int L = RD_LAT - 1;

    logic      [RD_LAT-1:0] r_vld;
    bank_sel_t [RD_LAT-1:0] r_sel;
    logic      [RD_LAT:0]   w_vext;
    bank_sel_t [RD_LAT:0]   w_sext;
    logic                   w_pend;

    assign w_vext = {r_vld, i_vld};
    assign w_sext = {r_sel, i_sel};

    // Anything still short of the output stage means more valid data is coming.
    always_comb begin
        w_pend = 1'b0;
        for (int s = 0; s < L; s++) begin
            w_pend = w_pend | r_vld[s];
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_vld <= '0;
            r_sel <= '0;
        end else begin
            r_vld <= w_vext[RD_LAT-1:0];
            // The output stage select only moves on valid data so mux_sel holds between elements.
            for (int s = 0; s < RD_LAT; s++) begin
                if (s != L || w_vext[s]) begin
                    r_sel[s] <= w_sext[s];
                end
            end
        end
    end

    assign o_vld  = r_vld[L];
    assign o_sel  = r_sel[L];
    assign o_pend = w_pend;
endmodule

// File: rtl/ram_bank_read_seq.sv
// Issues one interleaved bank read per cycle for a linear run and aligns mux select/valid to read latency.
module ram_bank_read_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W+1:0]      base_idx,
    input  logic [ADDR_W+1:0]      count,
    input  logic                   hold,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_BANKS-1:0]   bank_re,
    output logic [ADDR_W-1:0]      bank_addr,
    output bank_sel_t              mux_sel,
    output logic                   out_valid
);
    localparam int IDX_W = ADDR_W + 2;

    seq_state_t           r_state, w_next;
    logic [IDX_W-1:0]     r_idx, r_rem;
    logic [IDX_W-1:0]     w_cur_idx, w_cur_rem;
    logic                 w_issue, w_load;
    logic                 r_busy, r_done;
    logic [NUM_BANKS-1:0] r_bank_re;
    logic [ADDR_W-1:0]    r_bank_addr;
    bank_sel_t            r_re_sel;
    logic                 w_pend;

    // The start cycle issues the first read itself so bank_re appears in the cycle after start.
    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_load    = 1'b0;
        w_cur_idx = r_idx;
        w_cur_rem = r_rem;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cur_idx = base_idx;
                    w_cur_rem = count;
                    if (count == '0) begin
                        w_next = FIN;
                    end else begin
                        w_load  = 1'b1;
                        w_next  = ISSUE;
                        w_issue = !hold;
                    end
                end
            end
            ISSUE: w_issue = !hold;
            DRAIN: if (!w_pend && r_bank_re == '0) w_next = FIN;
            FIN:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_issue && w_cur_rem == IDX_W'(1)) w_next = DRAIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_rem       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bank_re   <= '0;
            r_bank_addr <= '0;
            r_re_sel    <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == FIN);
            if (w_issue) begin
                r_bank_re   <= bank_onehot(w_cur_idx[1:0]);
                r_bank_addr <= w_cur_idx[IDX_W-1:2];
                r_re_sel    <= w_cur_idx[1:0];
                r_idx       <= w_cur_idx + IDX_W'(1);
                r_rem       <= w_cur_rem - IDX_W'(1);
            end else begin
                r_bank_re <= '0;
                if (w_load) begin
                    r_idx <= w_cur_idx;
                    r_rem <= w_cur_rem;
                end
            end
        end
    end

    rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clk    (clk),
        .i_clr  (rst),
        .i_vld  (|r_bank_re),
        .i_sel  (r_re_sel),
        .o_vld  (out_valid),
        .o_sel  (mux_sel),
        .o_pend (w_pend)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign bank_re   = r_bank_re;
    assign bank_addr = r_bank_addr;
endmodule

// File: tb/tb_ram_bank_read_seq.sv
// Scoreboard bench: two instances (RD_LAT=1 and 2) share stimulus; expected reads/selects are queued per instance.
module tb_ram_bank_read_seq;
    localparam int ADDR_W = 8;
    localparam int IDX_W  = ADDR_W + 2;
    localparam int NDUT   = 2;

    typedef struct { int bank; int addr; } rd_t;
    typedef struct { int due;  int bank; } mv_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W-1:0] base_idx = '0;
    logic [IDX_W-1:0] count = '0;
    logic             hold = 1'b0;

    logic [NDUT-1:0]   busy_v, done_v, valid_v;
    logic [3:0]        re_v   [NDUT];
    logic [ADDR_W-1:0] addr_v [NDUT];
    logic [1:0]        sel_v  [NDUT];

    rd_t q_rd [NDUT][$];
    mv_t q_mv [NDUT][$];
    int  exp_done [NDUT];
    int  got_done [NDUT];
    int  last_sel [NDUT];
    int  last_v   [NDUT];
    bit  done_d   [NDUT];
    bit  cur_nz;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit rst_d  = 1'b1;
    bit hold_d = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_d  <= rst;
        hold_d <= hold;
        cyc    <= cyc + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ram_bank_read_seq #(.ADDR_W(ADDR_W), .RD_LAT(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .base_idx  (base_idx),
            .count     (count),
            .hold      (hold),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .bank_re   (re_v[g]),
            .bank_addr (addr_v[g]),
            .mux_sel   (sel_v[g]),
            .out_valid (valid_v[g])
        );

        always @(negedge clk) begin
            rd_t e;
            mv_t m;
            if (rst_d) begin
                chk($sformatf("rst_out%0d", g),
                    int'({busy_v[g], done_v[g], re_v[g], addr_v[g], sel_v[g], valid_v[g]}), 0);
                q_rd[g].delete();
                q_mv[g].delete();
                last_sel[g] = 0;
                done_d[g]   = 1'b0;
            end else begin
                if (hold_d) chk($sformatf("hold_no_re%0d", g), int'(re_v[g]), 0);
                if (re_v[g] != 4'd0) begin
                    if (q_rd[g].size() == 0) begin
                        chk($sformatf("extra_re%0d", g), int'(re_v[g]), 0);
                    end else begin
                        e = q_rd[g].pop_front();
                        chk($sformatf("bank_re%0d", g), int'(re_v[g]), 1 << e.bank);
                        chk($sformatf("bank_addr%0d", g), int'(addr_v[g]), e.addr);
                        m.due  = cyc + g + 1;
                        m.bank = e.bank;
                        q_mv[g].push_back(m);
                    end
                end
                if (valid_v[g]) begin
                    if (q_mv[g].size() == 0) begin
                        chk($sformatf("extra_valid%0d", g), 1, 0);
                    end else begin
                        m = q_mv[g].pop_front();
                        chk($sformatf("mux_sel%0d", g), int'(sel_v[g]), m.bank);
                        chk($sformatf("valid_lat%0d", g), cyc, m.due);
                        last_sel[g] = m.bank;
                    end
                    last_v[g] = cyc;
                end else begin
                    chk($sformatf("sel_hold%0d", g), int'(sel_v[g]), last_sel[g]);
                end
                if (done_v[g]) begin
                    got_done[g]++;
                    chk($sformatf("busy_at_done%0d", g), int'(busy_v[g]), 1);
                    chk($sformatf("drained%0d", g), q_rd[g].size() + q_mv[g].size(), 0);
                    if (cur_nz) chk($sformatf("done_after_valid%0d", g), cyc, last_v[g] + 1);
                end
                if (done_d[g]) chk($sformatf("busy_after_done%0d", g), int'(busy_v[g]), 0);
                done_d[g] = done_v[g];
            end
        end
    end

    // One run: expected reads are queued at start; optional hold window, ignored start, and mid-run reset.
    task automatic run(input int base, input int cnt, input int hold_at, input int hold_len,
                       input int busy_start_at, input bit do_rst);
        int i;
        rd_t e;
        @(negedge clk);
        for (int k = 0; k < cnt; k++) begin
            int idx;
            idx    = (base + k) % (1 << IDX_W);
            e.bank = idx % 4;
            e.addr = idx / 4;
            for (int g = 0; g < NDUT; g++) q_rd[g].push_back(e);
        end
        if (!do_rst) for (int g = 0; g < NDUT; g++) exp_done[g]++;
        cur_nz   = (cnt != 0);
        start    = 1'b1;
        base_idx = IDX_W'(base);
        count    = IDX_W'(cnt);
        i = 0;
        do begin
            @(negedge clk);
            i++;
            start = 1'b0;
            hold  = (i >= hold_at && i < hold_at + hold_len);
            if (i == busy_start_at) begin
                start    = 1'b1;
                base_idx = IDX_W'(100);
                count    = IDX_W'(3);
            end
            if (do_rst && i == 3) rst = 1'b1;
            if (do_rst && i == 5) rst = 1'b0;
            if (cnt == 0 && i == 1) begin
                chk("zero_done", int'(done_v), 3);
                chk("zero_busy", int'(busy_v), 3);
                chk("zero_re", int'(re_v[0] | re_v[1]), 0);
            end
        end while ((busy_v != '0 || i < 8) && i < 300);
        chk("run_timeout", int'(i >= 300), 0);
        hold = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            exp_done[g] = 0;
            got_done[g] = 0;
            last_sel[g] = 0;
            last_v[g]   = 0;
            done_d[g]   = 1'b0;
        end
        cur_nz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run(0,    8, -1, 0, -1, 1'b0);
        run(6,    3, -1, 0, -1, 1'b0);
        run(1022, 4, -1, 0, -1, 1'b0);
        run(10,   5,  2, 2, -1, 1'b0);
        run(0,    0, -1, 0, -1, 1'b0);
        run(20,   4, -1, 0,  2, 1'b0);
        run(0,    8, -1, 0, -1, 1'b1);
        run(300,  6,  4, 1, -1, 1'b0);
        repeat (4) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("done_count%0d", g), got_done[g], exp_done[g]);
            chk($sformatf("left_over%0d", g), q_rd[g].size() + q_mv[g].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
